// File: rtl/ps2_event_fifo.sv
// ----------------------------------------------------------------------------
// ps2_event_fifo
//
// Collapses PS/2 scan-code set 2 bytes into single key events and queues them
// in a small first-word-fall-through FIFO.
//
// Each event carries the final scan code plus two flags:
//   ext     - the code was preceded by an E0 prefix
//   release - the code was preceded by an F0 prefix (key up)
// Prefix bytes, the 8-byte Pause sequence, keyboard status/ack bytes and the
// print-screen "fake shift" codes never produce events.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   ps2_code    in   8   received byte, valid when strobe=1
//   strobe      in   1   one-cycle pulse, byte valid
//   err         in   1   one-cycle pulse, framing/parity error on this byte
//   ev_code     out  8   scan code of the head event
//   ev_ext      out  1   head event was E0-prefixed
//   ev_release  out  1   head event was F0-prefixed
//   ev_valid    out  1   FIFO not empty
//   ev_ready    in   1   consumer takes the head event this cycle
//   count       out  DEPTH_LOG2+1  number of events held
//   overflow    out  1   sticky, an event was dropped on a full FIFO
// ----------------------------------------------------------------------------
module ps2_event_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            ps2_code,
  input  logic                  strobe,
  input  logic                  err,
  output logic [7:0]            ev_code,
  output logic                  ev_ext,
  output logic                  ev_release,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [19:0] IDLE_LIMIT = 20'(TIMEOUT);
  localparam logic [19:0] IDLE_MAX   = 20'hF_FFFF;

  // Assembler states (legacy-compatible constant encoding)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_E0   = 3'd1;
  localparam logic [2:0] ST_F0   = 3'd2;
  localparam logic [2:0] ST_E0F0 = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  localparam logic [7:0] B_E0    = 8'hE0;
  localparam logic [7:0] B_E1    = 8'hE1;
  localparam logic [7:0] B_F0    = 8'hF0;
  localparam logic [7:0] B_FAKE  = 8'h12;

  // Bytes the keyboard sends about itself rather than about a key.
  function automatic logic is_status_byte(input logic [7:0] b);
    logic hit;
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: hit = 1'b1;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

  // --------------------------------------------------------------------------
  // Assembler
  // --------------------------------------------------------------------------
  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [2:0]  skip_cnt_r;
  logic [2:0]  skip_nxt_s;
  logic [19:0] idle_cnt_r;
  logic        timeout_s;
  logic        push_s;
  logic        push_ext_s;
  logic        push_rel_s;
  logic [9:0]  push_data_s;

  // A partial sequence is abandoned once the line has been quiet long enough;
  // a byte or error in the same cycle is handled first, so it wins.
  assign timeout_s = (idle_cnt_r == IDLE_LIMIT) && (state_r != ST_IDLE);

  // Event entries are packed {ext, release, code}.
  assign push_data_s = {push_ext_s, push_rel_s, ps2_code};

  // Next-state and push decode for the scan-code assembler.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    push_s      = 1'b0;
    push_ext_s  = 1'b0;
    push_rel_s  = 1'b0;

    if (err) begin
      // A corrupt byte makes any sequence in flight meaningless.
      state_nxt_s = ST_IDLE;
      skip_nxt_s  = 3'd0;
    end else if (strobe) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_code == B_E0) begin
            state_nxt_s = ST_E0;
          end else if (ps2_code == B_F0) begin
            state_nxt_s = ST_F0;
          end else if (ps2_code == B_E1) begin
            // E1 opens Pause; seven more bytes follow with no event.
            state_nxt_s = ST_SKIP;
            skip_nxt_s  = 3'd7;
          end else if (is_status_byte(ps2_code)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            push_s = 1'b1;
          end
        end
        ST_E0: begin
          if (ps2_code == B_F0) begin
            state_nxt_s = ST_E0F0;
          end else if (ps2_code == B_FAKE) begin
            state_nxt_s = ST_IDLE;
          end else begin
            push_s      = 1'b1;
            push_ext_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_F0: begin
          push_s      = 1'b1;
          push_rel_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        ST_E0F0: begin
          if (ps2_code == B_FAKE) begin
            state_nxt_s = ST_IDLE;
          end else begin
            push_s      = 1'b1;
            push_ext_s  = 1'b1;
            push_rel_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SKIP: begin
          // The guard on <=1 also recovers cleanly from a zero count.
          if (skip_cnt_r <= 3'd1) begin
            skip_nxt_s  = 3'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            skip_nxt_s  = skip_cnt_r - 3'd1;
            state_nxt_s = ST_SKIP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          skip_nxt_s  = 3'd0;
        end
      endcase
    end else if (timeout_s) begin
      state_nxt_s = ST_IDLE;
      skip_nxt_s  = 3'd0;
    end else begin
      state_nxt_s = state_r;
      skip_nxt_s  = skip_cnt_r;
    end
  end

  // Assembler state and Pause skip counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= 3'd0;
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_nxt_s;
    end
  end

  // Saturating idle counter, cleared by any line activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_r <= 20'd0;
    end else if (strobe || err) begin
      idle_cnt_r <= 20'd0;
    end else if (idle_cnt_r != IDLE_MAX) begin
      idle_cnt_r <= idle_cnt_r + 20'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  logic [9:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ev_valid_r;
  logic                  overflow_r;
  logic                  full_s;
  logic                  pop_s;
  logic                  wr_en_s;
  logic                  drop_s;

  assign full_s  = (count_r == CNT_FULL);
  assign pop_s   = ev_valid_r && ev_ready;
  // When full, a same-cycle pop frees the slot the write pointer points at.
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy count and the registered non-empty flag that tracks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= '0;
      ev_valid_r <= 1'b0;
    end else if (wr_en_s && !pop_s) begin
      count_r    <= count_r + CNT_ONE;
      ev_valid_r <= 1'b1;
    end else if (pop_s && !wr_en_s) begin
      count_r    <= count_r - CNT_ONE;
      ev_valid_r <= (count_r != CNT_ONE);
    end else begin
      count_r    <= count_r;
      ev_valid_r <= ev_valid_r;
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Head entry falls straight through from storage.
  assign ev_code    = mem_r[rd_ptr_r][7:0];
  assign ev_release = mem_r[rd_ptr_r][8];
  assign ev_ext     = mem_r[rd_ptr_r][9];
  assign ev_valid   = ev_valid_r;
  assign count      = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_event_fifo.sv
module tb_ps2_event_fifo;

  localparam int DL2 = 3;
  localparam int DEPTH = 1 << DL2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ps2_code = 8'h00;
  logic        strobe = 1'b0;
  logic        err = 1'b0;
  logic [7:0]  ev_code;
  logic        ev_ext;
  logic        ev_release;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [DL2:0] count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  ps2_event_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_code(ps2_code), .strobe(strobe), .err(err),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [7:0] c;
    logic       e;
    logic       r;
    logic       xv;
    logic [7:0] xc;
    logic       xe;
    logic       xr;
    int         xn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, sample 1 time unit later.
  task automatic step(input logic s, input logic [7:0] c, input logic e, input logic r);
    strobe = s; ps2_code = c; err = e; ev_ready = r;
    @(posedge clk);
    #1;
    strobe = 1'b0; err = 1'b0; ev_ready = 1'b0; ps2_code = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [7:0] c, input logic x, input logic r);
    chk({name, ".code"}, int'(ev_code), int'(c));
    chk({name, ".ext"}, int'(ev_ext), int'(x));
    chk({name, ".rel"}, int'(ev_release), int'(r));
  endtask

  function automatic vec_t v(input logic s, input logic [7:0] c, input logic e, input logic r,
                             input logic xv, input logic [7:0] xc, input logic xe,
                             input logic xr, input int xn);
    vec_t t;
    t.s = s; t.c = c; t.e = e; t.r = r;
    t.xv = xv; t.xc = xc; t.xe = xe; t.xr = xr; t.xn = xn;
    return t;
  endfunction

  // ---------------- reference model for the random phase ----------------
  logic [7:0] pend[$];
  logic [9:0] mq[$];
  int         idle_m;
  bit         ovf_m;

  function automatic bit status_b(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    pend.delete(); mq.delete(); idle_m = 0; ovf_m = 1'b0;
  endtask

  task automatic model_cycle(input logic s, input logic [7:0] c, input logic e, input logic r);
    bit pop, push, full, ext, rel;
    logic [9:0] ev;
    pop = (mq.size() != 0) && r;
    push = 1'b0;
    ev = 10'd0;
    if (e) begin
      pend.delete();
    end else if (s) begin
      if (pend.size() != 0 && pend[0] == 8'hE1) begin
        pend.push_back(c);
        if (pend.size() == 8) pend.delete();
      end else if (pend.size() == 0 && (c == 8'hE1 || c == 8'hE0)) begin
        pend.push_back(c);
      end else if (c == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0))) begin
        pend.push_back(c);
      end else begin
        ext = 1'b0; rel = 1'b0;
        foreach (pend[i]) begin
          if (pend[i] == 8'hE0) ext = 1'b1;
          if (pend[i] == 8'hF0) rel = 1'b1;
        end
        if (!(pend.size() == 0 && status_b(c)) && !(ext && c == 8'h12)) begin
          push = 1'b1;
          ev = {ext, rel, c};
        end
        pend.delete();
      end
    end else if (pend.size() != 0 && idle_m == TMO) begin
      pend.delete();
    end
    if (s || e) idle_m = 0;
    else if (idle_m < 20'hFFFFF) idle_m++;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back(ev);
      else ovf_m = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] pool [12];
    logic [7:0] b;
    logic s, e, r;
    vec_t t;

    // -------- reset state --------
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst.valid", int'(ev_valid), 0);
    chk("rst.count", int'(count), 0);
    chk("rst.ovf", int'(overflow), 0);
    chk_head("rst", 8'h00, 1'b0, 1'b0);

    // -------- table-driven directed vectors --------
    vecs.push_back(v(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1)); // single make
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0)); // pop it
    vecs.push_back(v(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h75, 0, 0, 1, 8'h75, 1, 1, 1)); // ext release
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0)); // fake shifts
    vecs.push_back(v(1, 8'h12, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h12, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hE1, 0, 0, 0, 8'h00, 0, 0, 0)); // Pause
    vecs.push_back(v(1, 8'h14, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hE1, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h14, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hAA, 0, 0, 0, 8'h00, 0, 0, 0)); // status bytes
    vecs.push_back(v(1, 8'hFA, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0)); // err abort
    vecs.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0)); // err+strobe
    vecs.push_back(v(1, 8'h1C, 1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'h1C, 1, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0)); // status after E0 is a key
    vecs.push_back(v(1, 8'hAA, 0, 0, 1, 8'hAA, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0)); // pop on empty

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      step(t.s, t.c, t.e, t.r);
      chk($sformatf("vec%0d.valid", i), int'(ev_valid), int'(t.xv));
      chk($sformatf("vec%0d.count", i), int'(count), t.xn);
      if (t.xv) chk_head($sformatf("vec%0d", i), t.xc, t.xe, t.xr);
    end
    chk("vec.ovf", int'(overflow), 0);

    // -------- overflow --------
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("ovf.count%0d", i), int'(count), (i > 8) ? 8 : i);
      chk($sformatf("ovf.flag%0d", i), int'(overflow), (i > 8) ? 1 : 0);
    end
    chk_head("ovf.head", 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b1);  // push with pop while full
    chk("ovf.pp.count", int'(count), 8);
    chk_head("ovf.pp.head", 8'h02, 1'b0, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      chk_head($sformatf("drain%0d", i), (i == 9) ? 8'h0A : 8'(i), 1'b0, 1'b0);
      chk($sformatf("drain%0d.valid", i), int'(ev_valid), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("drain.valid", int'(ev_valid), 0);
    chk("drain.count", int'(count), 0);
    chk("drain.ovf", int'(overflow), 1);

    // -------- reset mid-operation --------
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h23, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    chk("mid.count", int'(count), 3);
    do_reset();
    chk("mid.rst.valid", int'(ev_valid), 0);
    chk("mid.rst.count", int'(count), 0);
    chk("mid.rst.ovf", int'(overflow), 0);
    chk_head("mid.rst", 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("mid.after.count", int'(count), 1);
    chk_head("mid.after", 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // -------- timeout boundary --------
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TMO + 1) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("tmo.fire.count", int'(count), 1);
    chk_head("tmo.fire", 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TMO) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);  // lands on the timeout cycle, strobe wins
    chk("tmo.edge.count", int'(count), 1);
    chk_head("tmo.edge", 8'h1C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // -------- randomized run against the model --------
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hE1; pool[3] = 8'h12;
    pool[4] = 8'hAA; pool[5] = 8'hFA; pool[6] = 8'h00; pool[7] = 8'hFF;
    pool[8] = 8'hE0; pool[9] = 8'hF0; pool[10] = 8'h1C; pool[11] = 8'h75;
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) < 3) begin
        s = 1'b0; e = 1'b0;
        r = 1'b0;
        repeat ($urandom_range(20, 12)) begin
          model_cycle(1'b0, 8'h00, 1'b0, r);
          step(1'b0, 8'h00, 1'b0, r);
        end
      end
      s = ($urandom_range(99) < 35);
      e = ($urandom_range(99) < 3);
      r = ($urandom_range(99) < 30);
      b = ($urandom_range(1) == 0) ? pool[$urandom_range(11)] : 8'($urandom);
      model_cycle(s, b, e, r);
      step(s, b, e, r);
      chk("rnd.count", int'(count), mq.size());
      chk("rnd.valid", int'(ev_valid), (mq.size() != 0) ? 1 : 0);
      chk("rnd.ovf", int'(overflow), int'(ovf_m));
      if (mq.size() != 0) chk("rnd.head", int'({ev_ext, ev_release, ev_code}), int'(mq[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
